// File: rtl/mario_snd_cmd_rx.sv
// mario_snd_cmd_rx
// Sound-CPU-side receiver for the main-CPU sound command interface (7J data latch,
// 7M port bits, 7E00H strobe). Resynchronises the main-CPU controls into the
// I_CLK12M domain, captures each command byte when its write strobe ends, presents
// the byte to the I8039 on a MOVX read, and drives the sound CPU /INT, T0, T1 and
// PA[3:0] inputs plus a one-cycle skid trigger.
//
// Ports
//   I_CLK12M     sole clock
//   I_RESET      synchronous reset, active high
//   I_CMD_WR_n   7E00H write strobe from main CPU (async, active low)
//   I_7J_Q       command byte from the 7J latch
//   I_7M_Q       7M port: [0]=/INT req, [1]=T0, [2]=T1, [6:3]=PA3..PA0, [7]=skid
//   I_SND_RD_n   sound CPU external read strobe, active low
//   I_SND_CS     sound CPU command-port select
//   O_SND_DB     command byte to the sound CPU data bus, FF when not selected
//   O_SND_INT_n  sound CPU /INT, active low, registered
//   O_SND_T0     synchronised T0
//   O_SND_T1     synchronised T1
//   O_SND_PA     synchronised PA[3:0]
//   O_SKID_TRIG  one-cycle pulse on a skid request rising edge
//   O_CMD_PEND   command captured and not yet read
//   O_CMD_OVR    sticky: command overwritten while pending
module mario_snd_cmd_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned INT_MIN     = 16,
  parameter int unsigned INT_GUARD   = 4
) (
  input  logic       I_CLK12M,
  input  logic       I_RESET,
  input  logic       I_CMD_WR_n,
  input  logic [7:0] I_7J_Q,
  input  logic [7:0] I_7M_Q,
  input  logic       I_SND_RD_n,
  input  logic       I_SND_CS,
  output logic [7:0] O_SND_DB,
  output logic       O_SND_INT_n,
  output logic       O_SND_T0,
  output logic       O_SND_T1,
  output logic [3:0] O_SND_PA,
  output logic       O_SKID_TRIG,
  output logic       O_CMD_PEND,
  output logic       O_CMD_OVR
);

  localparam int unsigned CntMax = (INT_MIN > INT_GUARD) ? INT_MIN : INT_GUARD;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] CntMinLd   = CntW'(INT_MIN - 1);
  localparam logic [CntW-1:0] CntGuardLd = CntW'(INT_GUARD - 1);
  localparam logic [CntW-1:0] CntOne     = CntW'(1);

  // 7M inactive level: /INT request high, everything else low.
  localparam logic [7:0] Port7mIdle = 8'h01;

  typedef enum logic [1:0] {StIdle, StActive, StGuard} int_st_e;

  // Synchronisers
  logic [SYNC_STAGES-1:0] r_wr_sync;
  logic [7:0]             r_7m_sync [SYNC_STAGES];

  // Edge-detect history
  logic r_wr_prev;
  logic r_skid_prev;
  logic r_rd_prev;

  // Command path
  logic [7:0] r_cmd;
  logic [7:0] r_db;
  logic       r_pend;
  logic       r_ovr;
  logic       r_skid_trig;

  // /INT FSM
  int_st_e         r_state;
  logic [CntW-1:0] r_cnt;
  logic            r_int_n;

  logic       w_wr_sync;
  logic [7:0] w_7m;
  logic       w_capture;
  logic       w_rd;
  logic       w_rd_end;
  logic       w_req_n;
  logic       w_skid_rise;

  assign w_wr_sync   = r_wr_sync[SYNC_STAGES-1];
  assign w_7m        = r_7m_sync[SYNC_STAGES-1];
  // Capture on the end of the main-CPU write, when the 7J latch holds the new byte.
  assign w_capture   = ~r_wr_prev & w_wr_sync;
  assign w_rd        = I_SND_CS & ~I_SND_RD_n;
  assign w_rd_end    = r_rd_prev & ~w_rd;
  assign w_req_n     = w_7m[0];
  assign w_skid_rise = ~r_skid_prev & w_7m[7];

  always_ff @(posedge I_CLK12M) begin
    if (I_RESET) begin
      r_wr_sync <= '1;
      for (int i = 0; i < SYNC_STAGES; i++) r_7m_sync[i] <= Port7mIdle;
      r_wr_prev   <= 1'b1;
      r_skid_prev <= 1'b0;
    end else begin
      r_wr_sync    <= {r_wr_sync[SYNC_STAGES-2:0], I_CMD_WR_n};
      r_7m_sync[0] <= I_7M_Q;
      for (int i = 1; i < SYNC_STAGES; i++) r_7m_sync[i] <= r_7m_sync[i-1];
      r_wr_prev   <= w_wr_sync;
      r_skid_prev <= w_7m[7];
    end
  end

  always_ff @(posedge I_CLK12M) begin
    if (I_RESET) begin
      r_cmd       <= 8'h00;
      r_db        <= 8'hFF;
      r_pend      <= 1'b0;
      r_ovr       <= 1'b0;
      r_rd_prev   <= 1'b0;
      r_skid_trig <= 1'b0;
    end else begin
      r_rd_prev   <= w_rd;
      r_db        <= w_rd ? r_cmd : 8'hFF;
      r_skid_trig <= w_skid_rise;
      if (w_capture) begin
        r_cmd  <= I_7J_Q;
        r_pend <= 1'b1;
        // A read finishing this same cycle consumed the old byte, so it is not an overrun.
        if (r_pend && !w_rd_end) r_ovr <= 1'b1;
      end else if (w_rd_end) begin
        r_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge I_CLK12M) begin
    if (I_RESET) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_int_n <= 1'b1;
    end else begin
      case (r_state)
        StIdle: begin
          if (!w_req_n) begin
            r_state <= StActive;
            r_cnt   <= CntMinLd;
            r_int_n <= 1'b0;
          end
        end
        StActive: begin
          // Counter saturates at zero; a held request keeps /INT asserted.
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CntOne;
          end else if (w_req_n) begin
            r_state <= StGuard;
            r_cnt   <= CntGuardLd;
            r_int_n <= 1'b1;
          end
        end
        StGuard: begin
          if (r_cnt == '0) r_state <= StIdle;
          else             r_cnt   <= r_cnt - CntOne;
        end
        default: begin
          r_state <= StIdle;
          r_cnt   <= '0;
          r_int_n <= 1'b1;
        end
      endcase
    end
  end

  assign O_SND_DB    = r_db;
  assign O_SND_INT_n = r_int_n;
  assign O_SND_T0    = w_7m[1];
  assign O_SND_T1    = w_7m[2];
  assign O_SND_PA    = w_7m[6:3];
  assign O_SKID_TRIG = r_skid_trig;
  assign O_CMD_PEND  = r_pend;
  assign O_CMD_OVR   = r_ovr;

endmodule

// File: tb/tb_mario_snd_cmd_rx.sv
// Self-checking bench for mario_snd_cmd_rx. Command bytes are pushed to a
// scoreboard queue when written and popped when the sound CPU reads them.
module tb_mario_snd_cmd_rx;

  localparam int unsigned SS     = 2;
  localparam int unsigned IMIN   = 16;
  localparam int unsigned IGUARD = 4;

  logic       clk = 1'b0;
  logic       I_RESET;
  logic       I_CMD_WR_n;
  logic [7:0] I_7J_Q;
  logic [7:0] I_7M_Q;
  logic       I_SND_RD_n;
  logic       I_SND_CS;
  logic [7:0] O_SND_DB;
  logic       O_SND_INT_n;
  logic       O_SND_T0;
  logic       O_SND_T1;
  logic [3:0] O_SND_PA;
  logic       O_SKID_TRIG;
  logic       O_CMD_PEND;
  logic       O_CMD_OVR;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  mario_snd_cmd_rx #(
    .SYNC_STAGES(SS),
    .INT_MIN    (IMIN),
    .INT_GUARD  (IGUARD)
  ) u_dut (
    .I_CLK12M   (clk),
    .I_RESET    (I_RESET),
    .I_CMD_WR_n (I_CMD_WR_n),
    .I_7J_Q     (I_7J_Q),
    .I_7M_Q     (I_7M_Q),
    .I_SND_RD_n (I_SND_RD_n),
    .I_SND_CS   (I_SND_CS),
    .O_SND_DB   (O_SND_DB),
    .O_SND_INT_n(O_SND_INT_n),
    .O_SND_T0   (O_SND_T0),
    .O_SND_T1   (O_SND_T1),
    .O_SND_PA   (O_SND_PA),
    .O_SKID_TRIG(O_SKID_TRIG),
    .O_CMD_PEND (O_CMD_PEND),
    .O_CMD_OVR  (O_CMD_OVR)
  );

  // Advance n clocks; inputs driven and outputs sampled 1 ns after the edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_idle();
    I_CMD_WR_n = 1'b1;
    I_7J_Q     = 8'h00;
    I_7M_Q     = 8'h01;
    I_SND_RD_n = 1'b1;
    I_SND_CS   = 1'b0;
  endtask

  task automatic do_reset();
    I_RESET = 1'b1;
    tick();
    I_RESET = 1'b0;
    exp_q.delete();
    tick();
  endtask

  // Write one byte and wait until the capture has happened.
  task automatic drive_wr(input logic [7:0] b);
    I_7J_Q     = b;
    I_CMD_WR_n = 1'b0;
    tick(3);
    I_CMD_WR_n = 1'b1;
    exp_q.delete();
    exp_q.push_back(b);
    tick(SS + 1);
  endtask

  // Two-cycle MOVX read; returns the byte seen and PEND after the read ends.
  task automatic do_read(output logic [7:0] db, output logic pend_after);
    I_SND_CS   = 1'b1;
    I_SND_RD_n = 1'b0;
    tick();
    db = O_SND_DB;
    tick();
    I_SND_RD_n = 1'b1;
    I_SND_CS   = 1'b0;
    tick();
    pend_after = O_CMD_PEND;
  endtask

  task automatic test_reset();
    logic [20:0] got;
    logic [20:0] want;
    I_RESET    = 1'b1;
    I_CMD_WR_n = 1'b0;
    I_7J_Q     = 8'h5A;
    I_7M_Q     = 8'hFE;
    I_SND_RD_n = 1'b0;
    I_SND_CS   = 1'b1;
    tick();
    got  = {O_SND_DB, O_SND_INT_n, O_SND_T0, O_SND_T1, O_SND_PA, O_SKID_TRIG, O_CMD_PEND,
            O_CMD_OVR, 4'h0};
    want = {8'hFF, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0};
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required %h", got, want);
    end
    set_idle();
    I_RESET = 1'b0;
    exp_q.delete();
    tick(SS + 2);
    n_tests++;
    if ({O_SND_INT_n, O_CMD_PEND, O_SND_DB} !== {1'b1, 1'b0, 8'hFF}) begin
      n_fail++;
      $display("FAIL reset_release: got int_n=%b pend=%b db=%h required 1 0 ff",
               O_SND_INT_n, O_CMD_PEND, O_SND_DB);
    end
  endtask

  task automatic test_capture();
    logic [7:0] db;
    logic       p;
    logic [7:0] e;
    I_7J_Q     = 8'hA5;
    I_CMD_WR_n = 1'b0;
    tick(3);
    I_CMD_WR_n = 1'b1;
    exp_q.push_back(8'hA5);
    tick(SS);
    n_tests++;
    if (O_CMD_PEND !== 1'b0) begin
      n_fail++;
      $display("FAIL capture_early: got pend=%b required 0", O_CMD_PEND);
    end
    tick();
    n_tests++;
    if (O_CMD_PEND !== 1'b1) begin
      n_fail++;
      $display("FAIL capture_pend: got pend=%b required 1", O_CMD_PEND);
    end
    n_tests++;
    if (O_SND_DB !== 8'hFF) begin
      n_fail++;
      $display("FAIL capture_db_idle: got %h required ff", O_SND_DB);
    end
    do_read(db, p);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
    n_tests++;
    if (db !== e) begin
      n_fail++;
      $display("FAIL capture_read: got %h required %h", db, e);
    end
    n_tests++;
    if (p !== 1'b0 || O_SND_DB !== 8'hFF) begin
      n_fail++;
      $display("FAIL capture_read_end: got pend=%b db=%h required 0 ff", p, O_SND_DB);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] db;
    logic       p;
    logic [7:0] e;
    drive_wr(8'h11);
    n_tests++;
    if (O_CMD_OVR !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_first: got %b required 0", O_CMD_OVR);
    end
    drive_wr(8'h22);
    n_tests++;
    if ({O_CMD_OVR, O_CMD_PEND} !== 2'b11) begin
      n_fail++;
      $display("FAIL ovr_set: got ovr=%b pend=%b required 1 1", O_CMD_OVR, O_CMD_PEND);
    end
    do_read(db, p);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
    n_tests++;
    if (db !== e || O_CMD_OVR !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_read: got db=%h ovr=%b required %h 1", db, O_CMD_OVR, e);
    end

    // Read-end and capture on the same edge, with the old byte still pending.
    do_reset();
    drive_wr(8'h44);
    I_7J_Q     = 8'h33;
    I_CMD_WR_n = 1'b0;
    I_SND_CS   = 1'b1;
    I_SND_RD_n = 1'b0;
    tick();
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
    n_tests++;
    if (O_SND_DB !== e) begin
      n_fail++;
      $display("FAIL same_cycle_first_read: got %h required %h", O_SND_DB, e);
    end
    tick(2);
    I_CMD_WR_n = 1'b1;
    exp_q.push_back(8'h33);
    tick(SS);
    I_SND_RD_n = 1'b1;
    I_SND_CS   = 1'b0;
    tick();
    n_tests++;
    if ({O_CMD_PEND, O_CMD_OVR} !== 2'b10) begin
      n_fail++;
      $display("FAIL same_cycle_pend_ovr: got pend=%b ovr=%b required 1 0", O_CMD_PEND, O_CMD_OVR);
    end
    do_read(db, p);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
    n_tests++;
    if (db !== e || p !== 1'b0) begin
      n_fail++;
      $display("FAIL same_cycle_read: got db=%h pend=%b required %h 0", db, p, e);
    end
  endtask

  task automatic test_int_min();
    int k;
    int lo;
    int hi;
    I_7M_Q[0] = 1'b0;
    tick();
    I_7M_Q[0] = 1'b1;
    k = 0;
    while (O_SND_INT_n !== 1'b0 && k < 10) begin
      tick();
      k++;
    end
    n_tests++;
    if (O_SND_INT_n !== 1'b0) begin
      n_fail++;
      $display("FAIL int_assert: got int_n=%b required 0 within 10 clk", O_SND_INT_n);
    end
    lo = 0;
    while (O_SND_INT_n === 1'b0 && lo < 100) begin
      lo++;
      tick();
    end
    n_tests++;
    if (lo != IMIN) begin
      n_fail++;
      $display("FAIL int_min_width: got %0d clk low required %0d", lo, IMIN);
    end
    hi = 0;
    repeat (IGUARD + 4) begin
      if (O_SND_INT_n === 1'b1) hi++;
      tick();
    end
    n_tests++;
    if (hi != IGUARD + 4) begin
      n_fail++;
      $display("FAIL int_stays_high: got %0d clk high required %0d", hi, IGUARD + 4);
    end
  endtask

  task automatic test_int_level();
    int k;
    I_7M_Q[0] = 1'b0;
    tick(40);
    n_tests++;
    if (O_SND_INT_n !== 1'b0) begin
      n_fail++;
      $display("FAIL int_level_held: got int_n=%b required 0", O_SND_INT_n);
    end
    I_7M_Q[0] = 1'b1;
    k = 0;
    while (O_SND_INT_n === 1'b0 && k < 20) begin
      tick();
      k++;
    end
    n_tests++;
    if (k < SS || k > SS + 1) begin
      n_fail++;
      $display("FAIL int_level_release: got %0d clk to release required %0d..%0d", k, SS, SS + 1);
    end
    tick(IGUARD + 4);
  endtask

  task automatic test_guard();
    int k;
    int h;
    I_7M_Q[0] = 1'b0;
    tick();
    I_7M_Q[0] = 1'b1;
    k = 0;
    while (O_SND_INT_n !== 1'b0 && k < 10) begin
      tick();
      k++;
    end
    k = 0;
    while (O_SND_INT_n !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    // /INT has just risen; re-request one clock later and hold it.
    h = 0;
    while (O_SND_INT_n === 1'b1 && h < 50) begin
      h++;
      tick();
      if (h == 1) I_7M_Q[0] = 1'b0;
    end
    n_tests++;
    if (h < IGUARD || h >= 50) begin
      n_fail++;
      $display("FAIL guard_width: got %0d clk high required >= %0d then low", h, IGUARD);
    end
    I_7M_Q[0] = 1'b1;
    tick(IMIN + IGUARD + 8);
    n_tests++;
    if (O_SND_INT_n !== 1'b1) begin
      n_fail++;
      $display("FAIL guard_recover: got int_n=%b required 1", O_SND_INT_n);
    end
  endtask

  task automatic test_ports_skid();
    logic [7:0] pats [3];
    logic [7:0] pat;
    logic [6:0] prev_o;
    logic [6:0] want;
    int pulses;
    int first_at;
    pats[0] = 8'b0_101101_1;
    pats[1] = 8'b0_010010_1;
    pats[2] = 8'b0_111111_1;
    for (int i = 0; i < 3; i++) begin
      prev_o = {O_SND_T0, O_SND_T1, O_SND_PA, 1'b0};
      pat    = pats[i];
      I_7M_Q = pat;
      tick();
      n_tests++;
      if ({O_SND_T0, O_SND_T1, O_SND_PA, 1'b0} !== prev_o) begin
        n_fail++;
        $display("FAIL ports_early[%0d]: got %b required %b", i,
                 {O_SND_T0, O_SND_T1, O_SND_PA, 1'b0}, prev_o);
      end
      tick();
      want = {pat[1], pat[2], pat[6:3], 1'b0};
      n_tests++;
      if ({O_SND_T0, O_SND_T1, O_SND_PA, 1'b0} !== want) begin
        n_fail++;
        $display("FAIL ports_follow[%0d]: got %b required %b", i,
                 {O_SND_T0, O_SND_T1, O_SND_PA, 1'b0}, want);
      end
    end
    for (int r = 0; r < 3; r++) begin
      // Rising, falling, rising again.
      I_7M_Q[7] = (r != 1);
      pulses   = 0;
      first_at = -1;
      for (int c = 1; c <= 8; c++) begin
        tick();
        if (O_SKID_TRIG === 1'b1) begin
          pulses++;
          if (first_at < 0) first_at = c;
        end
      end
      n_tests++;
      if (pulses != ((r != 1) ? 1 : 0)) begin
        n_fail++;
        $display("FAIL skid_pulses[%0d]: got %0d required %0d", r, pulses, (r != 1) ? 1 : 0);
      end
      if (r == 0) begin
        n_tests++;
        if (first_at != SS + 1) begin
          n_fail++;
          $display("FAIL skid_latency: got %0d clk required %0d", first_at, SS + 1);
        end
      end
    end
    set_idle();
    tick(SS + 2);
  endtask

  task automatic test_reset_mid();
    int k;
    int lo;
    drive_wr(8'h77);
    I_7M_Q[0] = 1'b0;
    tick();
    I_7M_Q[0] = 1'b1;
    k = 0;
    while (O_SND_INT_n !== 1'b0 && k < 10) begin
      tick();
      k++;
    end
    tick(3);
    I_RESET = 1'b1;
    tick();
    n_tests++;
    if ({O_SND_INT_n, O_CMD_PEND} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_mid: got int_n=%b pend=%b required 1 0", O_SND_INT_n, O_CMD_PEND);
    end
    I_RESET = 1'b0;
    exp_q.delete();
    lo = 0;
    repeat (IMIN + 4) begin
      tick();
      if (O_SND_INT_n !== 1'b1 || O_CMD_PEND !== 1'b0) lo++;
    end
    n_tests++;
    if (lo != 0) begin
      n_fail++;
      $display("FAIL reset_mid_after: got %0d active clk required 0", lo);
    end
  endtask

  initial begin
    set_idle();
    I_RESET = 1'b1;
    tick(2);
    I_RESET = 1'b0;
    tick(3);
    test_reset();
    test_capture();
    test_overrun();
    test_int_min();
    test_int_level();
    test_guard();
    test_ports_skid();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
